// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester (0) and a
//   data load/store requester (1). Arbitration is round-robin and runs in the
//   IDLE slot that separates accesses. Each granted access holds the port
//   for exactly MEM_LAT cycles. The address is latched on the grant edge and
//   held stable until the access completes.
//
// Ports
//   clk            rising-edge system clock
//   reset          synchronous, active-low
//   req0 / addr0   requester 0 level request and address
//   req1 / addr1   requester 1 level request and address
//   gnt0 / gnt1    requester owns the port (one-hot or idle)
//   done0 / done1  one-cycle completion pulse, in the last access cycle
//   mem_en         memory access active
//   mem_addr       latched address of the granted requester
//   sel            steering select for the shared data path (0 = req0, 1 = req1)
//
// Every output comes from a flop. The flop inputs are derived from the
// next-state values, so the outputs line up exactly with the state register.

module mem_port_arbiter #(
  parameter int unsigned NBits   = 32,
  parameter int unsigned MEM_LAT = 2   // legal range 1..255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [NBits-1:0] addr0,
  input  logic             req1,
  input  logic [NBits-1:0] addr1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             mem_en,
  output logic [NBits-1:0] mem_addr,
  output logic             sel
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(MEM_LAT - 1);

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic             last, last_nxt;
  logic [NBits-1:0] addr_nxt;
  logic             sel_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    addr_nxt  = mem_addr;
    sel_nxt   = sel;
    unique case (state)
      IDLE: begin
        // On a tie, the requester that was not granted last wins. 'last'
        // tracks the most recent grant, so a lone request also counts.
        if (req0 && (!req1 || last)) begin
          state_nxt = BUSY0;
          cnt_nxt   = CNT_LOAD;
          addr_nxt  = addr0;
          sel_nxt   = 1'b0;
          last_nxt  = 1'b0;
        end else if (req1) begin
          state_nxt = BUSY1;
          cnt_nxt   = CNT_LOAD;
          addr_nxt  = addr1;
          sel_nxt   = 1'b1;
          last_nxt  = 1'b1;
        end
      end
      BUSY0, BUSY1: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      mem_addr <= '0;
      sel      <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      mem_en   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last     <= last_nxt;
      mem_addr <= addr_nxt;
      sel      <= sel_nxt;
      gnt0     <= (state_nxt == BUSY0);
      gnt1     <= (state_nxt == BUSY1);
      // The done pulse lands in the BUSY cycle whose count is zero. With
      // MEM_LAT=1 this is the grant cycle itself.
      done0    <= (state_nxt == BUSY0) && (cnt_nxt == '0);
      done1    <= (state_nxt == BUSY1) && (cnt_nxt == '0);
      mem_en   <= (state_nxt != IDLE);
    end
  end

endmodule
